// File: rtl/noc_pkg.sv
// Shared NoC flit definitions: widths, flit types, field offsets and
// packing helpers used by the packetizer and the future depacketizer.
package noc_pkg;

  localparam int FLIT_W = 73;
  localparam int DATA_W = 64;
  localparam int DEST_W = 7;
  localparam int LEN_W  = 8;
  localparam int SRC_W  = 8;
  localparam int SEQ_W  = 7;

  localparam int TYPE_LSB = 71;
  localparam int ID_LSB   = 64;
  localparam int SRC_LSB  = 8;
  localparam int LEN_LSB  = 0;

  typedef enum logic [1:0] {
    HEAD      = 2'b00,
    BODY      = 2'b01,
    TAIL      = 2'b10,
    HEAD_TAIL = 2'b11
  } flit_type_t;

  typedef enum logic {
    IDLE = 1'b0,
    DATA = 1'b1
  } state_t;

  function automatic logic [FLIT_W-1:0] make_head(
    input flit_type_t        t,
    input logic [DEST_W-1:0] dest,
    input logic [SRC_W-1:0]  src,
    input logic [LEN_W-1:0]  len
  );
    return {t, dest, 48'b0, src, len};
  endfunction

  function automatic logic [FLIT_W-1:0] make_body(
    input flit_type_t        t,
    input logic [SEQ_W-1:0]  seq,
    input logic [DATA_W-1:0] word
  );
    return {t, seq, word};
  endfunction

  function automatic flit_type_t flit_type(
    input logic [FLIT_W-1:0] f
  );
    return flit_type_t'(f[FLIT_W-1:TYPE_LSB]);
  endfunction

  function automatic logic is_last(
    input logic [FLIT_W-1:0] f
  );
    return f[TYPE_LSB+1];
  endfunction

endpackage

// File: rtl/noc_packetizer.sv
// NoC transmitter: command + payload words in, HEAD/BODY/TAIL flits out
// through a single registered output slot on a valid/ready link.
module noc_packetizer
  import noc_pkg::*;
#(
  parameter logic [SRC_W-1:0] SRC_ID = 8'd0
) (
  input  logic              i_clk,
  input  logic              i_arst_n,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [DEST_W-1:0] i_cmd_dest,
  input  logic [LEN_W-1:0]  i_cmd_len,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_data_valid,
  output logic              o_data_ready,
  output logic [FLIT_W-1:0] o_flit,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_busy
);

  state_t              state_q, state_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic [SEQ_W-1:0]    seq_q, seq_d;
  logic                valid_d;
  logic [FLIT_W-1:0]   flit_d;
  logic                slot_free;
  logic                last;
  flit_type_t          ftype;

  assign slot_free = ~o_valid | i_ready;
  assign last      = (rem_q == 8'd1);
  assign o_busy    = (state_q == DATA) | o_valid;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      seq_q   <= '0;
      o_valid <= 1'b0;
      o_flit  <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      seq_q   <= seq_d;
      o_valid <= valid_d;
      o_flit  <= flit_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    seq_d        = seq_q;
    valid_d      = o_valid;
    flit_d       = o_flit;
    o_cmd_ready  = 1'b0;
    o_data_ready = 1'b0;
    ftype        = HEAD;

    // A completed transfer empties the slot unless refilled below.
    if (o_valid && i_ready) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        o_cmd_ready = slot_free;
        if (i_cmd_valid && slot_free) begin
          if (i_cmd_len == '0) begin
            ftype = HEAD_TAIL;
          end else begin
            ftype   = HEAD;
            state_d = DATA;
          end
          valid_d = 1'b1;
          flit_d  = make_head(ftype, i_cmd_dest,
                              SRC_ID, i_cmd_len);
          rem_d   = i_cmd_len;
          seq_d   = '0;
        end
      end
      DATA: begin
        o_data_ready = slot_free;
        if (i_data_valid && slot_free) begin
          if (last) begin
            ftype   = TAIL;
            state_d = IDLE;
          end else begin
            ftype = BODY;
          end
          valid_d = 1'b1;
          flit_d  = make_body(ftype, seq_q, i_data);
          seq_d   = seq_q + 7'd1;
          rem_d   = rem_q - 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
